// File: rtl/uart_frame_parser_if.sv
// ============================================================================
// Module   : uart_frame_parser_if
// Brief    : Byte-stream, frame-hold and error-strobe bundle of uart_frame_parser.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_endofpacket;
    logic       frm_valid;
    logic       frm_ack;
    logic [7:0] frm_cmd;
    logic [7:0] frm_len;
    logic [7:0] frm_rd_addr;
    logic [7:0] frm_rd_data;
    logic       err_chk;
    logic       err_len;
    logic       err_abort;
    logic       err_ovf;

    modport master (
        output rx_data, rx_data_ready, rx_endofpacket, frm_ack, frm_rd_addr,
        input  frm_valid, frm_cmd, frm_len, frm_rd_data,
        input  err_chk, err_len, err_abort, err_ovf
    );

    modport slave (
        input  rx_data, rx_data_ready, rx_endofpacket, frm_ack, frm_rd_addr,
        output frm_valid, frm_cmd, frm_len, frm_rd_data,
        output err_chk, err_len, err_abort, err_ovf
    );
endinterface

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Parses SYNC/CMD/LEN/payload[/CHK] frames and holds one frame for a consumer.
//            Define UART_FRAME_PARSER_CHECKSUM_EN to require the trailing XOR check byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_frame_parser_if.slave bus
);

    localparam int         c_AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         c_DEPTH   = 1 << c_AW;
    localparam logic [8:0] c_MAX_LEN = 9'(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd5;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] c_DONE    = S_CHK;
`else
    localparam logic [2:0] c_DONE    = S_HOLD;
`endif

    logic [2:0] r_state;
    logic [7:0] r_cmd;
    logic [7:0] r_len;
    logic [7:0] r_idx;
    logic [7:0] r_rd_data;
    logic       r_err_len;
    logic       r_err_abort;
    logic       r_err_ovf;
    logic [7:0] r_mem [0:c_DEPTH-1];
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_err_chk;
`endif

    logic [7:0] w_idx_nxt;
    logic       w_in_frame;
    logic       w_wr_en;

    assign w_idx_nxt  = r_idx + 8'd1;
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_LEN) ||
                        (r_state == S_PAYLOAD)
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                        || (r_state == S_CHK)
`endif
                        ;
    // An end-of-packet coinciding with a byte aborts, so the byte is never written.
    assign w_wr_en    = (r_state == S_PAYLOAD) && bus.rx_data_ready && !bus.rx_endofpacket;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'h00;
            r_len       <= 8'h00;
            r_idx       <= 8'h00;
            r_err_len   <= 1'b0;
            r_err_abort <= 1'b0;
            r_err_ovf   <= 1'b0;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
            r_xor       <= 8'h00;
            r_err_chk   <= 1'b0;
`endif
        end else begin
            r_err_len   <= 1'b0;
            r_err_abort <= 1'b0;
            r_err_ovf   <= 1'b0;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
            r_err_chk   <= 1'b0;
`endif
            if (w_in_frame && bus.rx_endofpacket) begin
                r_err_abort <= 1'b1;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.rx_data_ready && (bus.rx_data == SYNC_BYTE))
                            r_state <= S_CMD;
                    end
                    S_CMD: begin
                        if (bus.rx_data_ready) begin
                            r_cmd   <= bus.rx_data;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                            r_xor   <= bus.rx_data;
`endif
                            r_state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (bus.rx_data_ready) begin
                            if ({1'b0, bus.rx_data} > c_MAX_LEN) begin
                                r_err_len <= 1'b1;
                                r_state   <= S_IDLE;
                            end else begin
                                r_len   <= bus.rx_data;
                                r_idx   <= 8'h00;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                                r_xor   <= r_xor ^ bus.rx_data;
`endif
                                r_state <= (bus.rx_data == 8'h00) ? c_DONE : S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (bus.rx_data_ready) begin
                            r_idx <= w_idx_nxt;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                            r_xor <= r_xor ^ bus.rx_data;
`endif
                            if (w_idx_nxt == r_len)
                                r_state <= c_DONE;
                        end
                    end
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                    S_CHK: begin
                        if (bus.rx_data_ready) begin
                            if (bus.rx_data == r_xor) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_err_chk <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                    end
`endif
                    S_HOLD: begin
                        // The held frame is never overwritten; late bytes are only reported.
                        if (bus.rx_data_ready)
                            r_err_ovf <= 1'b1;
                        if (bus.frm_ack)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_idx[c_AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= 8'h00;
        else if ({1'b0, bus.frm_rd_addr} < c_MAX_LEN)
            r_rd_data <= r_mem[bus.frm_rd_addr[c_AW-1:0]];
        else
            r_rd_data <= 8'h00;
    end

    assign bus.frm_valid   = (r_state == S_HOLD);
    assign bus.frm_cmd     = r_cmd;
    assign bus.frm_len     = r_len;
    assign bus.frm_rd_data = r_rd_data;
    assign bus.err_len     = r_err_len;
    assign bus.err_abort   = r_err_abort;
    assign bus.err_ovf     = r_err_ovf;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
    assign bus.err_chk     = r_err_chk;
`else
    assign bus.err_chk     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// ============================================================================
// Module   : tb_uart_frame_parser
// Brief    : Scoreboard bench for uart_frame_parser (frames and error strobes).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_parser;

    localparam int c_MAX_LEN = 16;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] len;
        logic [7:0] pl [16];
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    frame_t     frm_q [$];
    int         err_q [$];
    logic [7:0] pl_buf [16];

    uart_frame_parser_if u_if ();

    uart_frame_parser #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (c_MAX_LEN)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Error kinds: 1=chk 2=len 3=abort 4=ovf
    task automatic note_err(input int kind);
        if (err_q.size() == 0)
            check_eq("unexpected_err_strobe", kind, 0);
        else
            check_eq("err_kind", kind, err_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (u_if.err_chk)   note_err(1);
        if (u_if.err_len)   note_err(2);
        if (u_if.err_abort) note_err(3);
        if (u_if.err_ovf)   note_err(4);
    end

    task automatic send_byte(input logic [7:0] b, input logic eop);
        @(negedge clk);
        u_if.rx_data        = b;
        u_if.rx_data_ready  = 1'b1;
        u_if.rx_endofpacket = eop;
        @(negedge clk);
        u_if.rx_data_ready  = 1'b0;
        u_if.rx_endofpacket = 1'b0;
    endtask

    task automatic pulse_eop();
        @(negedge clk);
        u_if.rx_endofpacket = 1'b1;
        @(negedge clk);
        u_if.rx_endofpacket = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input bit good);
        frame_t     f;
        logic [7:0] x;
        f.cmd = cmd;
        f.len = len;
        f.pl  = pl_buf;
        if (good) frm_q.push_back(f);
        x = cmd ^ len;
        send_byte(8'hA5, 1'b0);
        send_byte(cmd, 1'b0);
        send_byte(len, 1'b0);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl_buf[i], 1'b0);
            x = x ^ pl_buf[i];
        end
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
        if (!good) err_q.push_back(1);
        send_byte(good ? x : (x ^ 8'h01), 1'b0);
`endif
    endtask

    task automatic wait_frame(input bit do_ack);
        frame_t f;
        int     n = 0;
        while (!u_if.frm_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("frm_valid_up", u_if.frm_valid, 1);
        if (frm_q.size() == 0) begin
            check_eq("frm_q_nonempty", frm_q.size(), 1);
            return;
        end
        f = frm_q.pop_front();
        check_eq("frm_cmd", u_if.frm_cmd, f.cmd);
        check_eq("frm_len", u_if.frm_len, f.len);
        for (int i = 0; i < int'(f.len); i++) begin
            u_if.frm_rd_addr = 8'(i);
            @(negedge clk);
            check_eq("frm_rd_data", u_if.frm_rd_data, f.pl[i]);
        end
        u_if.frm_rd_addr = 8'(c_MAX_LEN);
        @(negedge clk);
        check_eq("rd_out_of_range", u_if.frm_rd_data, 0);
        if (do_ack) begin
            u_if.frm_ack = 1'b1;
            @(negedge clk);
            u_if.frm_ack = 1'b0;
            check_eq("frm_valid_after_ack", u_if.frm_valid, 0);
        end
    endtask

    initial begin
        u_if.rx_data        = 8'h00;
        u_if.rx_data_ready  = 1'b0;
        u_if.rx_endofpacket = 1'b0;
        u_if.frm_ack        = 1'b0;
        u_if.frm_rd_addr    = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_frm_valid", u_if.frm_valid, 0);
        check_eq("rst_frm_cmd", u_if.frm_cmd, 0);
        check_eq("rst_frm_len", u_if.frm_len, 0);
        check_eq("rst_rd_data", u_if.frm_rd_data, 0);
        check_eq("rst_strobes", {u_if.err_chk, u_if.err_len, u_if.err_abort, u_if.err_ovf}, 0);
        rst = 1'b0;

        // Reference frame A5 12 02 34 56 [72]
        pl_buf[0] = 8'h34;
        pl_buf[1] = 8'h56;
        send_frame(8'h12, 8'h02, 1'b1);
        wait_frame(1'b1);

`ifdef UART_FRAME_PARSER_CHECKSUM_EN
        send_frame(8'h12, 8'h02, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("bad_chk_no_valid", u_if.frm_valid, 0);
`endif
        send_frame(8'h07, 8'h00, 1'b1);
        wait_frame(1'b1);

        // Over-long length, then a maximum-length frame
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        err_q.push_back(2);
        send_byte(8'h11, 1'b0);
        for (int i = 0; i < 16; i++) pl_buf[i] = 8'($urandom_range(0, 255));
        send_frame(8'h3C, 8'd16, 1'b1);
        wait_frame(1'b1);

        // Abort on a line gap, then abort coinciding with a byte
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h34, 1'b0);
        err_q.push_back(3);
        pulse_eop();
        send_byte(8'hA5, 1'b0);
        err_q.push_back(3);
        send_byte(8'hA5, 1'b1);
        check_eq("abort_no_valid", u_if.frm_valid, 0);
        pl_buf[0] = 8'hDE; pl_buf[1] = 8'hAD; pl_buf[2] = 8'hBE;
        send_frame(8'h44, 8'd3, 1'b1);
        wait_frame(1'b1);

        // Overflow while held, line gap ignored in HOLD, then ack coinciding with a byte
        for (int i = 0; i < 4; i++) pl_buf[i] = 8'(8'h90 + i);
        send_frame(8'h5A, 8'd4, 1'b1);
        err_q.push_back(4);
        send_byte(8'hA5, 1'b0);
        err_q.push_back(4);
        send_byte(8'h77, 1'b0);
        pulse_eop();
        wait_frame(1'b0);
        err_q.push_back(4);
        u_if.frm_ack       = 1'b1;
        u_if.rx_data       = 8'h55;
        u_if.rx_data_ready = 1'b1;
        @(negedge clk);
        u_if.frm_ack       = 1'b0;
        u_if.rx_data_ready = 1'b0;
        check_eq("ack_ovf_valid_low", u_if.frm_valid, 0);

        // Reset mid-payload abandons silently
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_valid", u_if.frm_valid, 0);
        check_eq("rst_mid_len", u_if.frm_len, 0);
        pl_buf[0] = 8'h01; pl_buf[1] = 8'h80;
        send_frame(8'hC3, 8'd2, 1'b1);
        wait_frame(1'b1);

        repeat (3) @(negedge clk);
        check_eq("err_q_drained", err_q.size(), 0);
        check_eq("frm_q_drained", frm_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
